// File: rtl/hazard_pkg.sv
// Shared types and constants for the D-stage hazard scoreboard and its MDU busy counter.
// Stage indices count pipeline stages after D; tnew/tuse fields are carried at a fixed max width.
package hazard_pkg;

  localparam int STG_D = 0;
  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  localparam int TNEW_MAX_W = 8;
  localparam logic [TNEW_MAX_W-1:0] TUSE_NONE = '1;

  typedef struct packed {
    logic [4:0]            wa;
    logic [TNEW_MAX_W-1:0] tnew;
  } sb_entry_t;

  typedef enum logic {
    MDU_MULT = 1'b0,
    MDU_DIV  = 1'b1
  } mdu_kind_e;

  function automatic logic [TNEW_MAX_W-1:0] tnew_decay(input logic [TNEW_MAX_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_MAX_W'(1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bundle: decoded operands in, stall/enable/forward controls out.
// Purely combinational path; no handshake, the pipeline obeys the enables every cycle.
interface hazard_scoreboard_if #(
  parameter int NUM_STAGES = 3,
  parameter int TNEW_W     = 3
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic [4:0]        d_wa;
  logic [TNEW_W-1:0] d_rs_tuse;
  logic [TNEW_W-1:0] d_rt_tuse;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic              ext_stall;

  logic              stall;
  logic              ifu_en;
  logic              f2d_en;
  logic              d2e_en;
  logic              d2e_flush;
  logic              e2m_en;
  logic              m2w_en;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic              mdu_busy;

  modport master (
    output d_rs, d_rt, d_wa, d_rs_tuse, d_rt_tuse, d_tnew,
    output d_md_start, d_md_div, d_md_use, ext_stall,
    input  stall, ifu_en, f2d_en, d2e_en, d2e_flush, e2m_en, m2w_en,
    input  fwd_rs_sel, fwd_rt_sel, mdu_busy
  );

  modport slave (
    input  d_rs, d_rt, d_wa, d_rs_tuse, d_rt_tuse, d_tnew,
    input  d_md_start, d_md_div, d_md_use, ext_stall,
    output stall, ifu_en, f2d_en, d2e_en, d2e_flush, e2m_en, m2w_en,
    output fwd_rs_sel, fwd_rt_sel, mdu_busy
  );

endinterface

// File: rtl/hazard_scoreboard_mdu_busy_ctr.sv
// Multiply/divide busy window: loads the unit latency on issue, counts down to zero.
// Busy is registered state; keeps counting through pipeline freezes.
module mdu_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  mdu_kind_e kind,
  output logic      busy
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (kind == MDU_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/tuse hazard unit: per-stage {wa,tnew} scoreboard, forwarding select and stall/enable generation.
// Controls are combinational from state and D inputs; ext_stall freezes everything except the MDU count.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int TNEW_W     = 3,
  parameter int MULT_LAT   = 5,
  parameter int DIV_LAT    = 10
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  hz
);

  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  sb_entry_t             sb_ent [1:NUM_STAGES];
  logic [NUM_STAGES:1]   rs_match;
  logic [NUM_STAGES:1]   rt_match;
  logic [NUM_STAGES:1]   rs_late;
  logic [NUM_STAGES:1]   rt_late;
  logic                  rs_used;
  logic                  rt_used;
  logic                  md_busy;
  logic                  md_stall;
  logic                  md_load;
  logic                  stall;
  logic [SEL_W-1:0]      rs_sel;
  logic [SEL_W-1:0]      rt_sel;

  assign rs_used = (hz.d_rs_tuse != TUSE_NONE[TNEW_W-1:0]);
  assign rt_used = (hz.d_rt_tuse != TUSE_NONE[TNEW_W-1:0]);

  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_sb
    sb_entry_t ent_in;
    sb_entry_t ent_d;
    sb_entry_t ent_q;

    // A stalled D instruction enters E as a bubble, so no producer is recorded.
    if (k == STG_E) begin : g_head
      always_comb begin
        ent_in = '0;
        if (!stall) begin
          ent_in.wa   = hz.d_wa;
          ent_in.tnew = TNEW_MAX_W'(hz.d_tnew);
        end
      end
    end else begin : g_tail
      always_comb begin
        ent_in.wa   = sb_ent[k-1].wa;
        ent_in.tnew = tnew_decay(sb_ent[k-1].tnew);
      end
    end

    always_comb begin
      ent_d = hz.ext_stall ? ent_q : ent_in;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ent_q <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end

    assign sb_ent[k]   = ent_q;
    assign rs_match[k] = (ent_q.wa != 5'd0) && (ent_q.wa == hz.d_rs);
    assign rt_match[k] = (ent_q.wa != 5'd0) && (ent_q.wa == hz.d_rt);
    assign rs_late[k]  = rs_match[k] && rs_used && (TNEW_MAX_W'(hz.d_rs_tuse) < ent_q.tnew);
    assign rt_late[k]  = rt_match[k] && rt_used && (TNEW_MAX_W'(hz.d_rt_tuse) < ent_q.tnew);
  end

  // Youngest producer wins, so scan from the oldest stage down to E.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (rs_match[k]) rs_sel = SEL_W'(k);
      if (rt_match[k]) rt_sel = SEL_W'(k);
    end
  end

  assign md_stall = (hz.d_md_start || hz.d_md_use) && md_busy;
  assign stall    = (|rs_late) || (|rt_late) || md_stall;
  assign md_load  = hz.d_md_start && !stall && !hz.ext_stall;

  mdu_busy_ctr #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_mdu_busy_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (md_load),
    .kind (mdu_kind_e'(hz.d_md_div)),
    .busy (md_busy)
  );

  assign hz.stall      = stall;
  assign hz.ifu_en     = !hz.ext_stall && !stall;
  assign hz.f2d_en     = !hz.ext_stall && !stall;
  assign hz.d2e_en     = !hz.ext_stall && !stall;
  assign hz.d2e_flush  = !hz.ext_stall && stall;
  assign hz.e2m_en     = !hz.ext_stall;
  assign hz.m2w_en     = !hz.ext_stall;
  assign hz.fwd_rs_sel = rs_sel;
  assign hz.fwd_rt_sel = rt_sel;
  assign hz.mdu_busy   = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Instruction-level bench for hazard_scoreboard: expectations queued at drive time, checked at negedge.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam logic [2:0] NU = 3'd7;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic [2:0] rs_tu;
    logic [2:0] rt_tu;
    logic [2:0] tnew;
    logic       md_start;
    logic       md_div;
    logic       md_use;
  } instr_t;

  typedef struct {
    string      tag;
    logic       ext;
    logic       stall;
    logic [1:0] frs;
    logic [1:0] frt;
    logic       busy;
    logic       cf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t me;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_STAGES(3), .TNEW_W(3)) hz();

  hazard_scoreboard #(
    .NUM_STAGES (3),
    .TNEW_W     (3),
    .MULT_LAT   (5),
    .DIV_LAT    (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] rs, input logic [2:0] rs_tu,
                                input logic [4:0] rt, input logic [2:0] rt_tu,
                                input logic [4:0] wa, input logic [2:0] tnew);
    instr_t i;
    i.rs = rs; i.rs_tu = rs_tu; i.rt = rt; i.rt_tu = rt_tu;
    i.wa = wa; i.tnew = tnew;
    i.md_start = 1'b0; i.md_div = 1'b0; i.md_use = 1'b0;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(5'd0, NU, 5'd0, NU, 5'd0, 3'd0);
  endfunction

  function automatic instr_t alu(input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, 3'd1, rt, 3'd1, wa, 3'd1);
  endfunction

  function automatic instr_t lw(input logic [4:0] wa, input logic [4:0] rs);
    return mk(rs, 3'd1, 5'd0, NU, wa, 3'd2);
  endfunction

  function automatic instr_t beq(input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, 3'd0, rt, 3'd0, 5'd0, 3'd0);
  endfunction

  function automatic instr_t md(input logic div, input logic [4:0] rs, input logic [4:0] rt);
    instr_t i;
    i = mk(rs, 3'd1, rt, 3'd1, 5'd0, 3'd0);
    i.md_start = 1'b1;
    i.md_div = div;
    return i;
  endfunction

  function automatic instr_t mfx(input logic [4:0] wa);
    instr_t i;
    i = mk(5'd0, NU, 5'd0, NU, wa, 3'd1);
    i.md_use = 1'b1;
    return i;
  endfunction

  task automatic apply(input instr_t i, input logic ext);
    hz.d_rs = i.rs; hz.d_rt = i.rt; hz.d_wa = i.wa;
    hz.d_rs_tuse = i.rs_tu; hz.d_rt_tuse = i.rt_tu; hz.d_tnew = i.tnew;
    hz.d_md_start = i.md_start; hz.d_md_div = i.md_div; hz.d_md_use = i.md_use;
    hz.ext_stall = ext;
  endtask

  task automatic step(input instr_t i, input logic ext, input string tag, input logic st,
                      input logic [1:0] frs, input logic [1:0] frt, input logic bz, input logic cf);
    exp_t e;
    @(posedge clk);
    #1;
    apply(i, ext);
    e.tag = tag; e.ext = ext; e.stall = st; e.frs = frs; e.frt = frt; e.busy = bz; e.cf = cf;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int n);
    for (int j = 0; j < n; j++) step(nop(), 1'b0, "drain", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      chk({me.tag, ".stall"}, 32'(hz.stall), 32'(me.stall));
      chk({me.tag, ".flush"}, 32'(hz.d2e_flush), 32'(me.stall & ~me.ext));
      chk({me.tag, ".fe_en"}, 32'({hz.ifu_en, hz.f2d_en, hz.d2e_en}),
          (me.stall | me.ext) ? 32'd0 : 32'd7);
      chk({me.tag, ".be_en"}, 32'({hz.e2m_en, hz.m2w_en}), me.ext ? 32'd0 : 32'd3);
      chk({me.tag, ".busy"}, 32'(hz.mdu_busy), 32'(me.busy));
      if (me.cf) begin
        chk({me.tag, ".fwd_rs"}, 32'(hz.fwd_rs_sel), 32'(me.frs));
        chk({me.tag, ".fwd_rt"}, 32'(hz.fwd_rt_sel), 32'(me.frt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t hzd;
    rst = 1'b1;
    apply(nop(), 1'b0);

    // Reset: nothing may stall even with hazardous-looking D inputs.
    hzd = alu(5'd10, 5'd8, 5'd2);
    hzd.md_use = 1'b1;
    step(nop(), 1'b0, "rst0", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(hzd,   1'b0, "rst1", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;

    // rt forwarding from E and youngest-producer priority.
    step(alu(5'd11, 5'd1, 5'd2),  1'b0, "rt_p",  1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(alu(5'd3, 5'd5, 5'd11),  1'b0, "rt_c",  1'b0, 2'd0, 2'd1, 1'b0, 1'b1);
    step(alu(5'd12, 5'd0, 5'd0),  1'b0, "pri_a", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(alu(5'd12, 5'd0, 5'd0),  1'b0, "pri_b", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(alu(5'd4, 5'd12, 5'd0),  1'b0, "pri_c", 1'b0, 2'd1, 2'd0, 1'b0, 1'b1);
    drain(3);

    // Load-use: one bubble, then forward from M.
    step(lw(5'd8, 5'd1),          1'b0, "lu_lw",    1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(alu(5'd10, 5'd8, 5'd2),  1'b0, "lu_stall", 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    step(alu(5'd10, 5'd8, 5'd2),  1'b0, "lu_go",    1'b0, 2'd2, 2'd0, 1'b0, 1'b1);
    drain(3);

    // Branch right after ALU producer.
    step(alu(5'd9, 5'd1, 5'd2),   1'b0, "br_alu",   1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(beq(5'd9, 5'd3),         1'b0, "br_stall", 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    step(beq(5'd9, 5'd3),         1'b0, "br_go",    1'b0, 2'd2, 2'd0, 1'b0, 1'b1);
    drain(3);

    // tnew saturates at zero as the producer ages into W.
    step(alu(5'd15, 5'd1, 5'd2),  1'b0, "sat_alu", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(nop(),                   1'b0, "sat_n1",  1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(nop(),                   1'b0, "sat_n2",  1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(beq(5'd15, 5'd0),        1'b0, "sat_br",  1'b0, 2'd3, 2'd0, 1'b0, 1'b1);
    drain(1);

    // Register zero never creates a dependency.
    step(lw(5'd0, 5'd1),          1'b0, "r0_lw",  1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(alu(5'd10, 5'd0, 5'd2),  1'b0, "r0_use", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    drain(2);

    // div then mflo: 10 stall cycles; mult then mfhi: 5.
    step(md(1'b1, 5'd1, 5'd2),    1'b0, "div", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    for (int j = 0; j < 10; j++)
      step(mfx(5'd13),            1'b0, "div_wait", 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
    step(mfx(5'd13),              1'b0, "div_mflo", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(md(1'b0, 5'd1, 5'd2),    1'b0, "mul", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++)
      step(mfx(5'd14),            1'b0, "mul_wait", 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
    step(mfx(5'd14),              1'b0, "mul_mfhi", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    drain(3);

    // ext_stall freezes the scoreboard during a load-use but not the MDU count.
    step(md(1'b0, 5'd1, 5'd2),    1'b0, "ex_mul", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(lw(5'd8, 5'd1),          1'b0, "ex_lw",  1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++)
      step(alu(5'd10, 5'd8, 5'd2), 1'b1, "ex_frz", 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
    step(alu(5'd10, 5'd8, 5'd2),  1'b0, "ex_resume", 1'b1, 2'd0, 2'd0, 1'b1, 1'b0);
    step(alu(5'd10, 5'd8, 5'd2),  1'b0, "ex_go",     1'b0, 2'd2, 2'd0, 1'b0, 1'b1);
    drain(3);

    // Async reset mid-div with counter at 6 and a pending load-use.
    step(md(1'b1, 5'd1, 5'd2),    1'b0, "rd_div", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    step(nop(),                   1'b0, "rd_n1",  1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    step(nop(),                   1'b0, "rd_n2",  1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    step(nop(),                   1'b0, "rd_n3",  1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    step(lw(5'd8, 5'd1),          1'b0, "rd_lw",  1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    @(posedge clk);
    #1 apply(hzd, 1'b0);
    #1;
    chk("rd_pre_stall", 32'(hz.stall), 32'd1);
    chk("rd_pre_busy",  32'(hz.mdu_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rd_busy",   32'(hz.mdu_busy), 32'd0);
    chk("rd_stall",  32'(hz.stall), 32'd0);
    chk("rd_fwd_rs", 32'(hz.fwd_rs_sel), 32'd0);
    me.tag = "rd_hold"; me.ext = 1'b0; me.stall = 1'b0; me.frs = 2'd0; me.frt = 2'd0;
    me.busy = 1'b0; me.cf = 1'b1;
    exp_q.push_back(me);
    @(negedge clk);
    #2 rst = 1'b0;
    step(hzd,                     1'b0, "rd_after", 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    drain(3);

    @(negedge clk);
    #1;
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, meaning pipeline stages after D (index 1=E, 2=M, 3=W); legal range 2..6.
REQ-002 SHALL have parameter TNEW_W, default 3, meaning width of all tuse/tnew fields.
REQ-003 SHALL have parameter MULT_LAT, default 5, meaning mult busy cycles.
REQ-004 SHALL have parameter DIV_LAT, default 10, meaning div busy cycles.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising edge), then reset input 1.
REQ-006 SHALL have ports d_rs, d_rt, d_wa, each input 5: D-stage source/dest register addresses; 0 means none.
REQ-007 SHALL have ports d_rs_tuse, d_rt_tuse, d_tnew, each input TNEW_W: D-stage tuse per source and tnew of the result; all-ones tuse means unused.
REQ-008 SHALL have port d_md_start input 1 (mult/div in D), port d_md_div input 1 (1=div, 0=mult), port d_md_use input 1 (mfhi/mflo/mthi/mtlo in D).
REQ-009 SHALL have port ext_stall input 1: external freeze, e.g. memory wait.
REQ-010 SHALL have outputs stall, ifu_en, f2d_en, d2e_en, d2e_flush, e2m_en, m2w_en, each 1 bit.
REQ-011 SHALL have outputs fwd_rs_sel, fwd_rt_sel, each clog2(NUM_STAGES+1) bits: 0=register file, k=forward from stage k.
REQ-012 SHALL have output mdu_busy 1.

Function
REQ-013 SHALL hold a scoreboard of NUM_STAGES entries {wa, tnew}, one per stage.
REQ-014 SHALL, on each edge without ext_stall, load entry 1 with {d_wa, d_tnew}, or with {0, 0} when stall=1.
REQ-015 SHALL, in the same edge, shift entry k to k+1 with tnew decremented and saturating at 0; the last entry is discarded.
REQ-016 SHALL keep the whole scoreboard unchanged while ext_stall=1.
REQ-017 SHALL raise a source stall when some entry k has wa!=0, wa==src and src_tuse<tnew_k; an unused source (tuse all-ones) or src=0 SHALL never stall.
REQ-018 SHALL select fwd_*_sel as the lowest k with wa_k!=0 and wa_k==src, else 0; this is valid only when the stall is not raised.
REQ-019 SHALL load the MDU counter with MULT_LAT or DIV_LAT, per d_md_div, on an edge where d_md_start=1, stall=0 and ext_stall=0.
REQ-020 SHALL otherwise decrement the MDU counter to a floor of 0, including while ext_stall=1.
REQ-021 SHALL drive mdu_busy = (counter!=0).
REQ-022 SHALL raise an MDU stall when (d_md_start or d_md_use) and mdu_busy=1.
REQ-023 SHALL drive stall = rs stall or rt stall or MDU stall; it is combinational from state and D inputs.
REQ-024 SHALL drive, when ext_stall=0: ifu_en=f2d_en=d2e_en=~stall, d2e_flush=stall, e2m_en=m2w_en=1.
REQ-025 SHALL drive, when ext_stall=1: all *_en=0 and d2e_flush=0, with ext_stall taking precedence.
REQ-026 SHALL let a dependent instruction stalled behind a load issue exactly when tnew decays to tuse; no extra bubble.

Reset
REQ-027 SHALL clear, on reset assertion, all scoreboard entries to {0, 0} and the MDU counter to 0, immediately and independently of clk.
REQ-028 SHALL, during and after reset, give mdu_busy=0, and stall=0 for any D inputs; reset mid-mult/div aborts the busy window.

Structure
REQ-029 SHALL place in shared package hazard_pkg: stage index constants, TUSE_NONE (all-ones), the scoreboard entry struct, and MDU kind encoding.
REQ-030 SHALL instantiate one sub-module, mdu_busy_ctr (load/decrement/busy); scoreboard and compare logic are generate loops over NUM_STAGES.

Verification
REQ-031 SHALL check load-use: lw $8 (d_tnew=2) then addu with rs=8 (tuse=1) -> exactly 1 stall cycle, d2e_flush=1 that cycle; next cycle fwd_rs_sel=2.
REQ-032 SHALL check branch after ALU: addu $9 (tnew=1) then beq rs=9 (tuse=0) -> 1 stall; then fwd_rs_sel=2.
REQ-033 SHALL check register 0: lw $0 then addu rs=0 -> stall=0, fwd_rs_sel=0.
REQ-034 SHALL check MDU: div issued, then mflo next in D -> stall held 10 cycles, mdu_busy falls, mflo issues; mult gives 5 cycles.
REQ-035 SHALL check ext_stall=1 for 3 cycles during a pending load-use -> all *_en=0, flush=0, scoreboard frozen, MDU counter still decrements; the load-use stall resumes with 1 cycle remaining.
REQ-036 SHALL check async reset mid-div (counter=6) -> mdu_busy=0 immediately, stall=0, and the scoreboard is empty.
